// File: rtl/pipeline_pkg.sv
// Shared pipeline types: multiplier FSM states and default datapath width.
package pipeline_pkg;
  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;
endpackage

// File: rtl/mul_datapath.sv
// Shift-add multiplier registers: accumulator, multiplicand and multiplier shifters.
// MUL_EARLY_TERM_EN: report when the multiplier has no set bits left after this step.
module mul_datapath
  import pipeline_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc,
  output logic             mplier_done
);
  logic [WIDTH-1:0] mcand, mplier;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

`ifdef MUL_EARLY_TERM_EN
  // Upper bits clear means the shift in progress leaves the multiplier at zero.
  assign mplier_done = (mplier[WIDTH-1:1] == '0);
`else
  assign mplier_done = 1'b0;
`endif
endmodule

// File: rtl/mul_ctrl.sv
// Multi-cycle shift-add multiplier control: IDLE/BUSY/DONE FSM, step counter, stall/valid.
// MUL_EARLY_TERM_EN: finish as soon as the multiplier runs out of set bits.
module mul_ctrl
  import pipeline_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MulStartE,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             MulStallE,
  output logic             MulValidE,
  output logic [WIDTH-1:0] MulResultE
);
  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t       state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, res_q;
  logic             load, step, mplier_done, busy_end;

  mul_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .a           (SrcAE),
    .b           (SrcBE),
    .acc         (acc),
    .mplier_done (mplier_done)
  );

  assign busy_end = (count == CW'(1)) || mplier_done;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    MulStallE = 1'b0;
    MulValidE = 1'b0;
    case (state)
      IDLE: if (MulStartE && !FlushE) begin
        load      = 1'b1;
        MulStallE = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        step      = 1'b1;
        MulStallE = 1'b1;
        if (FlushE)        state_nxt = IDLE;
        else if (busy_end) state_nxt = DONE;
      end
      DONE: begin
        MulValidE = !FlushE;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Start decode is combinational; keep the stall quiet while held in reset.
    if (!reset) MulStallE = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      if (load)      count <= CW'(WIDTH);
      else if (step) count <= count - CW'(1);
      if (state == DONE && !FlushE) res_q <= acc;
    end
  end

  assign MulResultE = (state == DONE) ? acc : res_q;
endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a cycle-level reference model of stall/valid/result.
module tb_mul_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MulStartE = 1'b0;
  logic        FlushE = 1'b0;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        MulStallE, MulValidE;
  logic [31:0] MulResultE;

  int tests = 0;
  int fails = 0;

  mul_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .MulStartE  (MulStartE),
    .FlushE     (FlushE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .MulStallE  (MulStallE),
    .MulValidE  (MulValidE),
    .MulResultE (MulResultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycles from start to the valid pulse, derived from the operand's bit length.
  function automatic int lat_of(input logic [31:0] b);
    int k;
    k = 1;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
`ifndef MUL_EARLY_TERM_EN
    k = 32;
`endif
    return k + 1;
  endfunction

  // Reference model: an operation is a product plus a deadline counted from its start.
  bit          m_active = 0;
  int          m_age = 0;
  int          m_lat = 0;
  logic [31:0] m_prod = '0;
  logic [31:0] m_last = '0;

  initial begin
    logic e_stall, e_valid;
    logic [31:0] e_res;
    forever begin
      @(negedge clk);
      if (!reset) begin
        e_stall = 1'b0;
        e_valid = 1'b0;
        e_res   = '0;
      end else begin
        e_stall = m_active ? (m_age < m_lat) : (MulStartE && !FlushE);
        e_valid = m_active && (m_age == m_lat) && !FlushE;
        e_res   = e_valid ? m_prod : m_last;
      end
      check("model_stall", 32'(MulStallE), 32'(e_stall));
      check("model_valid", 32'(MulValidE), 32'(e_valid));
      if (!(reset && m_active && m_age == m_lat && FlushE))
        check("model_result", MulResultE, e_res);

      if (!reset) begin
        m_active = 0;
        m_last   = '0;
      end else if (m_active) begin
        if (FlushE) m_active = 0;
        else if (m_age == m_lat) begin
          m_active = 0;
          m_last   = m_prod;
        end else m_age++;
      end else if (MulStartE && !FlushE) begin
        m_active = 1;
        m_age    = 1;
        m_prod   = SrcAE * SrcBE;
        m_lat    = lat_of(SrcBE);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns start-relative valid cycle, result, stall count.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output int stalls);
    SrcAE = a;
    SrcBE = b;
    MulStartE = 1'b1;
    FlushE = 1'b0;
    lat = -1;
    res = 'x;
    stalls = 0;
    for (int c = 0; c < 100 && lat < 0; c++) begin
      @(negedge clk);
      if (MulStallE) stalls++;
      if (MulValidE) begin
        lat = c;
        res = MulResultE;
      end
      tick();
      MulStartE = 1'b0;
    end
    if (lat < 0) check("mul_timeout", 32'(lat), 32'(0));
  endtask

  initial begin
    int lat, st, npulse, p1, p2;
    logic [31:0] res, r1, r2;

    // Reset with a start request pending: everything must stay quiet.
    MulStartE = 1'b1;
    SrcAE = 32'd1;
    SrcBE = 32'd1;
    tick();
    @(negedge clk);
    check("rst_stall", 32'(MulStallE), 32'd0);
    check("rst_valid", 32'(MulValidE), 32'd0);
    check("rst_result", MulResultE, 32'd0);
    tick();
    MulStartE = 1'b0;
    reset = 1'b1;
    tick();

    do_mul(32'd7, 32'd6, lat, res, st);
    check("7x6_result", res, 32'd42);
`ifdef MUL_EARLY_TERM_EN
    check("7x6_lat", 32'(lat), 32'd4);
    check("7x6_stalls", 32'(st), 32'd4);
`else
    check("7x6_lat", 32'(lat), 32'd33);
    check("7x6_stalls", 32'(st), 32'd33);
`endif

    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, st);
    check("ffxff_result", res, 32'h0000_0001);
    check("ffxff_lat", 32'(lat), 32'd33);

    do_mul(32'd5, 32'd3, lat, res, st);
    check("5x3_result", res, 32'd15);
`ifdef MUL_EARLY_TERM_EN
    check("5x3_lat", 32'(lat), 32'd3);
`else
    check("5x3_lat", 32'(lat), 32'd33);
`endif

    do_mul(32'h1234, 32'd0, lat, res, st);
    check("x0_result", res, 32'd0);
`ifdef MUL_EARLY_TERM_EN
    check("x0_lat", 32'(lat), 32'd2);
`else
    check("x0_lat", 32'(lat), 32'd33);
`endif

    do_mul(32'h0001_0000, 32'h0001_0000, lat, res, st);
    check("wrap16_result", res, 32'd0);
    do_mul(32'h8000_0001, 32'd2, lat, res, st);
    check("wrap_top_result", res, 32'd2);

    // Flush in IDLE suppresses the start.
    SrcAE = 32'd2;
    SrcBE = 32'd2;
    MulStartE = 1'b1;
    FlushE = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", 32'(MulStallE), 32'd0);
    tick();
    MulStartE = 1'b0;
    FlushE = 1'b0;
    tick();

    // Flush in the 10th BUSY cycle aborts without a valid pulse.
    SrcAE = 32'h0000_FFFF;
    SrcBE = 32'hFFFF_FFFF;
    MulStartE = 1'b1;
    tick();
    MulStartE = 1'b0;
    repeat (9) tick();
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    @(negedge clk);
    check("flush_stall", 32'(MulStallE), 32'd0);
    check("flush_valid", 32'(MulValidE), 32'd0);
    npulse = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (MulValidE) npulse++;
    end
    check("flush_no_pulse", 32'(npulse), 32'd0);
    tick();
    do_mul(32'd9, 32'd11, lat, res, st);
    check("after_flush_result", res, 32'd99);

    // Reset in the 5th BUSY cycle clears outputs immediately.
    SrcAE = 32'hFFFF_FFFF;
    SrcBE = 32'd3;
    MulStartE = 1'b1;
    tick();
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("midrst_stall", 32'(MulStallE), 32'd0);
    check("midrst_valid", 32'(MulValidE), 32'd0);
    check("midrst_result", MulResultE, 32'd0);
    tick();
    MulStartE = 1'b0;
    reset = 1'b1;
    tick();
    do_mul(32'd3, 32'd4, lat, res, st);
    check("after_rst_result", res, 32'd12);

    // Start held across DONE: two operations, one IDLE cycle between them.
    SrcAE = 32'd6;
    SrcBE = 32'd7;
    MulStartE = 1'b1;
    npulse = 0;
    p1 = -1;
    p2 = -1;
    r1 = '0;
    r2 = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (MulValidE) begin
        npulse++;
        if (npulse == 1) begin p1 = c; r1 = MulResultE; end
        if (npulse == 2) begin p2 = c; r2 = MulResultE; end
      end
      tick();
      if (npulse >= 2) MulStartE = 1'b0;
    end
    MulStartE = 1'b0;
    check("b2b_pulses", 32'(npulse), 32'd2);
    check("b2b_r1", r1, 32'd42);
    check("b2b_r2", r2, 32'd42);
`ifdef MUL_EARLY_TERM_EN
    check("b2b_p1", 32'(p1), 32'd4);
    check("b2b_p2", 32'(p2), 32'd9);
`else
    check("b2b_p1", 32'(p1), 32'd33);
    check("b2b_p2", 32'(p2), 32'd67);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
